// File: rtl/sum_arbiter.sv
// Round-robin arbiter that grants one requester an accumulation session and
// sums its words until a zero word (done), a carry out (err) or a dropped request.
module sum_arbiter #(
   parameter int N_REQ = 4,
   parameter int W     = 16
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ-1:0]           vld,
   input  logic [N_REQ*W-1:0]         data,
   output logic [N_REQ-1:0]           gnt,
   output logic                       rdy,
   output logic                       done,
   output logic                       err,
   output logic [$clog2(N_REQ)-1:0]   res_id,
   output logic [W-1:0]               sum
);

   localparam int IW = $clog2(N_REQ);
   localparam logic [IW:0] NREQ_W = (IW+1)'(N_REQ);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACC  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   logic [1:0]    r_state;
   logic [IW-1:0] r_gnt_idx;
   logic [IW-1:0] r_rr_ptr;
   logic [IW-1:0] r_res_id;
   logic [W-1:0]  r_acc;
   logic [W-1:0]  r_sum;

   logic [W-1:0]  w_words [N_REQ];
   logic [W-1:0]  w_word;
   logic          w_vld_g;
   logic          w_req_g;
   logic [W:0]    w_add;
   logic          w_win_found;
   logic [IW-1:0] w_win_idx;
   logic [IW:0]   w_cand;
   logic [IW:0]   w_ptr_inc;
   logic [IW-1:0] w_ptr_next;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_lane
         assign w_words[gi] = data[gi*W +: W];
         assign gnt[gi]     = (r_state == S_ACC) && (r_gnt_idx == IW'(gi));
      end
   endgenerate

   assign w_word  = w_words[r_gnt_idx];
   assign w_vld_g = vld[r_gnt_idx];
   assign w_req_g = req[r_gnt_idx];
   // W+1-bit accumulate: bit W is the carry that aborts the session
   assign w_add   = {1'b0, r_acc} + {1'b0, w_word};

   // Scan downward so the candidate closest to rr_ptr is the last to win
   always_comb begin
      w_win_found = 1'b0;
      w_win_idx   = '0;
      w_cand      = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_cand = {1'b0, r_rr_ptr} + (IW+1)'(k);
         if (w_cand >= NREQ_W) begin
            w_cand = w_cand - NREQ_W;
         end
         if (req[w_cand[IW-1:0]]) begin
            w_win_found = 1'b1;
            w_win_idx   = w_cand[IW-1:0];
         end
      end
   end

   always_comb begin
      w_ptr_inc  = {1'b0, r_gnt_idx} + (IW+1)'(1);
      w_ptr_next = (w_ptr_inc == NREQ_W) ? '0 : w_ptr_inc[IW-1:0];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= S_IDLE;
         r_gnt_idx <= '0;
         r_rr_ptr  <= '0;
         r_res_id  <= '0;
         r_acc     <= '0;
         r_sum     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_win_found) begin
                  r_state   <= S_ACC;
                  r_gnt_idx <= w_win_idx;
                  r_acc     <= '0;
               end
            end
            S_ACC: begin
               if (w_vld_g) begin
                  if (w_word == '0) begin
                     r_state  <= S_FIN;
                     r_sum    <= r_acc;
                     r_res_id <= r_gnt_idx;
                  end else if (w_add[W]) begin
                     r_state  <= S_ERR;
                     r_res_id <= r_gnt_idx;
                     r_acc    <= w_add[W-1:0];
                  end else begin
                     r_acc <= w_add[W-1:0];
                  end
               end else if (!w_req_g) begin
                  r_state  <= S_IDLE;
                  r_rr_ptr <= w_ptr_next;
               end
            end
            S_FIN, S_ERR: begin
               r_state  <= S_IDLE;
               r_rr_ptr <= w_ptr_next;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rdy    = (r_state == S_ACC);
   assign done   = (r_state == S_FIN);
   assign err    = (r_state == S_ERR);
   assign res_id = r_res_id;
   assign sum    = r_sum;

endmodule
